// File: rtl/frame_writer.sv
// frame_writer
//   Writes one frame of pixels (capture) or a solid colour (clear) into one
//   of NUM_FRAMES slots of a frame store through its port A. Port B has
//   priority: while port_b_wr is high no port A write is issued and the
//   pixel count holds.
//
// Ports
//   clk, rst_n        clock (rising edge) and async active-low reset
//   start, clear_req  one-cycle requests, honoured only in IDLE
//   frame_sel         target slot index
//   fill_colour       colour written by a clear
//   pix_valid/ready   upstream pixel handshake, pix_data the pixel
//   port_b_wr         port B is writing this cycle
//   bram_addr/we/data port A write interface (registered)
//   busy              capture or clear in progress
//   frame_done        pulse on the final write of an operation
//   err               pulse after a request with an out-of-range slot
//
// state   | meaning
// IDLE    | waiting for start or clear_req
// CAPTURE | writing accepted upstream pixels into the slot
// CLEAR   | writing fill_colour into every pixel of the slot

module frame_writer #(
  parameter int N            = 15,
  parameter int W            = 16,
  parameter int FRAME_PIXELS = 6144,
  parameter int NUM_FRAMES   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clear_req,
  input  logic [2:0]   frame_sel,
  input  logic [W-1:0] fill_colour,
  input  logic         pix_valid,
  input  logic [W-1:0] pix_data,
  output logic         pix_ready,
  input  logic         port_b_wr,
  output logic [N-1:0] bram_addr,
  output logic         bram_we,
  output logic [W-1:0] bram_data,
  output logic         busy,
  output logic         frame_done,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, CAPTURE, CLEAR} state_t;

  localparam logic [N-1:0] FP_N = N'(FRAME_PIXELS);
  localparam logic [N-1:0] LAST = N'(FRAME_PIXELS - 1);

  state_t       state, next_state;
  logic [N-1:0] base, base_d;
  logic [N-1:0] count, count_d;
  logic [N-1:0] addr_d;
  logic [W-1:0] data_d;
  logic         we_d, done_d, err_d;
  logic         wr_go;
  logic [W-1:0] wr_val;
  logic         sel_ok;

  assign sel_ok    = 32'(frame_sel) < NUM_FRAMES;
  assign pix_ready = (state == CAPTURE) && !port_b_wr;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base       <= '0;
      count      <= '0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_data  <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= next_state;
      base       <= base_d;
      count      <= count_d;
      bram_we    <= we_d;
      bram_addr  <= addr_d;
      bram_data  <= data_d;
      frame_done <= done_d;
      err        <= err_d;
    end
  end

  always_comb begin
    next_state = state;
    base_d     = base;
    count_d    = count;
    we_d       = 1'b0;
    addr_d     = bram_addr;
    data_d     = bram_data;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_go      = 1'b0;
    wr_val     = bram_data;

    case (state)
      IDLE: begin
        if (start || clear_req) begin
          if (sel_ok) begin
            base_d     = N'(frame_sel) * FP_N;
            count_d    = '0;
            // clear has priority when both requests arrive together
            next_state = clear_req ? CLEAR : CAPTURE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (pix_valid && !port_b_wr) begin
          wr_go  = 1'b1;
          wr_val = pix_data;
        end
      end
      CLEAR: begin
        if (!port_b_wr) begin
          wr_go  = 1'b1;
          wr_val = fill_colour;
        end
      end
      default: next_state = IDLE;
    endcase

    // The write registered here appears on port A next cycle; the final
    // one drops back to IDLE so busy falls together with frame_done.
    if (wr_go) begin
      we_d    = 1'b1;
      addr_d  = base + count;
      data_d  = wr_val;
      count_d = count + 1'b1;
      if (count == LAST) begin
        done_d     = 1'b1;
        next_state = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
module tb_frame_writer;

  localparam int FP = 6144;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clear_req;
  logic [2:0]  frame_sel;
  logic [15:0] fill_colour;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        port_b_wr;
  logic [14:0] bram_addr;
  logic        bram_we;
  logic [15:0] bram_data;
  logic        busy, frame_done, err;

  int passed = 0;
  int total  = 0;

  int r_writes, r_bad_addr, r_bad_data, r_bad_lat, r_done, r_done_addr;
  int r_done_we, r_busy_after, r_bad_ready, r_stalls;

  frame_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_req(clear_req),
    .frame_sel(frame_sel), .fill_colour(fill_colour), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .port_b_wr(port_b_wr),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_data(bram_data),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a request and follows the operation cycle by cycle, collecting
  // statistics against the expected address/data/latency sequence.
  task automatic run_op(input bit do_clr, input bit do_start, input logic [2:0] sel,
                        input logic [15:0] col, input int stall_at,
                        input int stop_after, input int max_cyc);
    int   base, beat;
    bit   acc, stall;
    logic [14:0] exp_addr;
    logic [15:0] exp_data;
    r_writes = 0; r_bad_addr = 0; r_bad_data = 0; r_bad_lat = 0; r_done = 0;
    r_done_addr = -1; r_done_we = 0; r_busy_after = -1; r_bad_ready = 0;
    r_stalls = 0;
    base = sel * FP;
    beat = 0;
    frame_sel = sel; fill_colour = col;
    clear_req = do_clr; start = do_start;
    pix_valid = !do_clr; pix_data = 16'd0;
    tick();
    start = 1'b0; clear_req = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      stall = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 3);
      port_b_wr = stall;
      #1;
      if (stall) begin
        r_stalls++;
        if (pix_ready !== 1'b0) r_bad_ready++;
      end
      acc = do_clr ? (busy && !port_b_wr) : (pix_valid && pix_ready);
      tick();
      if (acc) begin
        beat++;
        pix_data = 16'(beat);
      end
      if (bram_we !== acc) r_bad_lat++;
      if (bram_we === 1'b1) begin
        exp_addr = 15'(base + r_writes);
        exp_data = do_clr ? col : 16'(r_writes);
        if (bram_addr !== exp_addr) r_bad_addr++;
        if (bram_data !== exp_data) r_bad_data++;
        r_writes++;
      end
      if (frame_done === 1'b1) begin
        r_done++;
        r_done_addr = int'(bram_addr);
        r_done_we = int'(bram_we);
        break;
      end
      if (stop_after > 0 && r_writes == stop_after) break;
    end
    port_b_wr = 1'b0;
    pix_valid = 1'b0;
    if (r_done > 0) begin
      tick();
      r_busy_after = int'(busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; clear_req = 0; frame_sel = 0; fill_colour = 0;
    pix_valid = 0; pix_data = 0; port_b_wr = 0;
    #12;
    total++;
    if ({bram_we, busy, frame_done, err, pix_ready} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {bram_we, busy, frame_done, err, pix_ready});
    else passed++;
    total++;
    if ({bram_addr, bram_data} !== 31'd0)
      $display("FAIL reset_bus: got addr %0d data %0d expected 0 0", bram_addr, bram_data);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    run_op(1'b0, 1'b1, 3'd2, 16'h0000, -1, 0, FP + 100);
    total++; if (r_writes !== FP) $display("FAIL cap_writes: got %0d expected %0d", r_writes, FP); else passed++;
    total++; if (r_bad_addr !== 0) $display("FAIL cap_addr: got %0d bad expected 0", r_bad_addr); else passed++;
    total++; if (r_bad_data !== 0) $display("FAIL cap_data: got %0d bad expected 0", r_bad_data); else passed++;
    total++; if (r_bad_lat !== 0) $display("FAIL cap_latency: got %0d bad expected 0", r_bad_lat); else passed++;
    total++; if (r_done !== 1) $display("FAIL cap_done: got %0d expected 1", r_done); else passed++;
    total++; if (r_done_addr !== 18431) $display("FAIL cap_done_addr: got %0d expected 18431", r_done_addr); else passed++;
    total++; if (r_done_we !== 1) $display("FAIL cap_done_we: got %0d expected 1", r_done_we); else passed++;
    total++; if (r_busy_after !== 0) $display("FAIL cap_busy_after: got %0d expected 0", r_busy_after); else passed++;
  endtask

  task automatic test_clear();
    run_op(1'b1, 1'b0, 3'd0, 16'hF81F, -1, 0, FP + 100);
    total++; if (r_writes !== FP) $display("FAIL clr_writes: got %0d expected %0d", r_writes, FP); else passed++;
    total++; if (r_bad_addr !== 0) $display("FAIL clr_addr: got %0d bad expected 0", r_bad_addr); else passed++;
    total++; if (r_bad_data !== 0) $display("FAIL clr_data: got %0d bad expected 0", r_bad_data); else passed++;
    total++; if (r_bad_lat !== 0) $display("FAIL clr_consecutive: got %0d bad expected 0", r_bad_lat); else passed++;
    total++; if (r_done_addr !== 6143) $display("FAIL clr_done_addr: got %0d expected 6143", r_done_addr); else passed++;
  endtask

  task automatic test_clear_wins();
    run_op(1'b1, 1'b1, 3'd1, 16'h07E0, -1, 0, FP + 100);
    total++; if (r_writes !== FP) $display("FAIL both_writes: got %0d expected %0d", r_writes, FP); else passed++;
    total++; if (r_bad_addr !== 0) $display("FAIL both_addr: got %0d bad expected 0", r_bad_addr); else passed++;
    total++; if (r_bad_data !== 0) $display("FAIL both_data: got %0d bad expected 0", r_bad_data); else passed++;
    total++; if (r_done_addr !== 12287) $display("FAIL both_done_addr: got %0d expected 12287", r_done_addr); else passed++;
  endtask

  task automatic test_bad_sel();
    frame_sel = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (err !== 1'b1) $display("FAIL badsel_err: got %b expected 1", err); else passed++;
    total++;
    if ({busy, pix_ready, bram_we} !== 3'b000)
      $display("FAIL badsel_idle: got %b expected 000", {busy, pix_ready, bram_we});
    else passed++;
    tick();
    total++; if (err !== 1'b0) $display("FAIL badsel_pulse: got %b expected 0", err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL badsel_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_stall();
    run_op(1'b0, 1'b1, 3'd3, 16'h0000, 20, 0, FP + 100);
    total++; if (r_stalls !== 3) $display("FAIL stall_cycles: got %0d expected 3", r_stalls); else passed++;
    total++; if (r_bad_ready !== 0) $display("FAIL stall_ready: got %0d bad expected 0", r_bad_ready); else passed++;
    total++; if (r_bad_lat !== 0) $display("FAIL stall_writes: got %0d bad expected 0", r_bad_lat); else passed++;
    total++; if (r_bad_addr !== 0) $display("FAIL stall_addr: got %0d bad expected 0", r_bad_addr); else passed++;
    total++; if (r_bad_data !== 0) $display("FAIL stall_data: got %0d bad expected 0", r_bad_data); else passed++;
    total++; if (r_writes !== FP) $display("FAIL stall_count: got %0d expected %0d", r_writes, FP); else passed++;
  endtask

  task automatic test_ignore_busy();
    int dones;
    int cyc;
    frame_sel = 3'd4; fill_colour = 16'h1234; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    frame_sel = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (err !== 1'b0) $display("FAIL busy_req_err: got %b expected 0", err); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL busy_req_busy: got %b expected 1", busy); else passed++;
    dones = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < FP + 100) begin
      tick();
      if (frame_done === 1'b1) dones++;
      cyc++;
    end
    total++; if (dones !== 1) $display("FAIL busy_req_done: got %0d expected 1", dones); else passed++;
  endtask

  task automatic test_reset_abort();
    int dones;
    run_op(1'b0, 1'b1, 3'd2, 16'h0000, -1, 100, 1000);
    total++; if (r_writes !== 100) $display("FAIL abort_writes: got %0d expected 100", r_writes); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bram_we, busy, frame_done, err, pix_ready} !== 5'b0 || {bram_addr, bram_data} !== 31'd0)
      $display("FAIL abort_async: got we %b busy %b addr %0d data %0d expected all 0", bram_we, busy, bram_addr, bram_data);
    else passed++;
    dones = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (frame_done === 1'b1 || busy === 1'b1) dones++;
    end
    total++; if (dones !== 0) $display("FAIL abort_idle: got %0d active cycles expected 0", dones); else passed++;
    run_op(1'b0, 1'b1, 3'd2, 16'h0000, -1, 0, FP + 100);
    total++; if (r_writes !== FP) $display("FAIL rerun_writes: got %0d expected %0d", r_writes, FP); else passed++;
    total++; if (r_bad_addr !== 0) $display("FAIL rerun_addr: got %0d bad expected 0", r_bad_addr); else passed++;
    total++; if (r_done_addr !== 18431) $display("FAIL rerun_done_addr: got %0d expected 18431", r_done_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_clear();
    test_clear_wins();
    test_bad_sel();
    test_stall();
    test_ignore_busy();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 The module SHALL have parameter N, default 15, meaning the frame-store address width.
REQ-002 The module SHALL have parameter W, default 16, meaning the pixel width (RGB565).
REQ-003 The module SHALL have parameter FRAME_PIXELS, default 6144, meaning pixels per frame (96x64).
REQ-004 The module SHALL have parameter NUM_FRAMES, default 5, meaning the number of frame slots, with NUM_FRAMES*FRAME_PIXELS <= 2**N.
REQ-005 The module SHALL have these ports:
- clk  in  1  the single clock; all logic is on its rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to capture one frame into slot frame_sel
- clear_req  in  1  one-cycle request to fill slot frame_sel with fill_colour
- frame_sel  in  3  target slot index
- fill_colour  in  W  colour used by clear
- pix_valid  in  1  upstream pixel valid
- pix_data  in  W  upstream pixel
- pix_ready  out  1  writer accepts a pixel this cycle
- port_b_wr  in  1  frame store port B is writing; port A must not write
- bram_addr  out  N  frame store port A address
- bram_we  out  1  frame store port A write enable
- bram_data  out  W  frame store port A write data
- busy  out  1  capture or clear in progress
- frame_done  out  1  one-cycle pulse on the final write of a capture or clear
- err  out  1  one-cycle pulse on a rejected request

Function
REQ-006 The FSM SHALL have exactly the states IDLE, CAPTURE and CLEAR.
REQ-007 In IDLE, clear_req with frame_sel < NUM_FRAMES SHALL latch base = frame_sel*FRAME_PIXELS, zero the pixel counter and enter CLEAR.
REQ-008 In IDLE, start with clear_req low and frame_sel < NUM_FRAMES SHALL latch base, zero the counter and enter CAPTURE.
REQ-009 When start and clear_req are both high in IDLE, clear SHALL win and start SHALL be dropped.
REQ-010 A request in IDLE with frame_sel >= NUM_FRAMES SHALL pulse err the next cycle and leave the FSM in IDLE.
REQ-011 start and clear_req SHALL be ignored outside IDLE, with no err pulse.
REQ-012 busy SHALL be high exactly while the FSM is in CAPTURE or CLEAR.
REQ-013 pix_ready SHALL equal (state == CAPTURE) AND NOT port_b_wr, combinationally.
REQ-014 A beat is accepted when pix_valid and pix_ready are high on the same edge.
- Next cycle: bram_we=1, bram_addr=base+count, bram_data=pix_data.
- count then increments.
REQ-015 In CLEAR, each cycle with port_b_wr low SHALL produce a write of fill_colour to base+count on the next cycle and increment count.
REQ-016 A cycle with port_b_wr high SHALL produce no write on the next cycle, and count SHALL hold.
REQ-017 bram_we SHALL be 0 in every cycle that has no write.
REQ-018 bram_addr and bram_data SHALL hold their last values when bram_we is 0.
REQ-019 When the write for count == FRAME_PIXELS-1 is issued:
- frame_done SHALL pulse in the same cycle as that bram_we.
- The FSM SHALL return to IDLE in that same cycle.
REQ-020 The address SHALL never exceed base+FRAME_PIXELS-1; arithmetic is N-bit unsigned with no wrap.
REQ-021 Latency from an accepted beat to its bram_we SHALL be exactly 1 cycle.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, count=0, base=0 and all outputs to 0.
REQ-023 Reset mid-operation SHALL abort the operation with no frame_done pulse; after release, the FSM SHALL wait in IDLE.

Verification
REQ-024 start, frame_sel=2; pix_valid held high with pixels 0..6143 -> 6144 writes to addresses 12288..18431 with data equal to the index; frame_done coincides with addr 18431; busy low on the next cycle.
REQ-025 clear_req, frame_sel=0, fill_colour=16'hF81F -> 6144 consecutive writes to addresses 0..6143; frame_done on the 6144th write.
REQ-026 start and clear_req together, frame_sel=1 -> CLEAR, writing fill_colour to 6144..12287.
REQ-027 start, frame_sel=5 -> err pulses once; busy, pix_ready and bram_we stay 0.
REQ-028 During CAPTURE, port_b_wr high for 3 cycles -> pix_ready low and no writes for those cycles; the address sequence resumes without a gap or duplicate.
REQ-029 rst_n low after 100 capture writes -> outputs 0 asynchronously, no frame_done; a fresh start rewrites from base.
